// File: rtl/pixel_pkg.sv
// Shared frame-state encoding and width-parametrised gray/binary helpers.
// The helpers operate on a 32-bit carrier; only the low 'w' bits are meaningful.
package pixel_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ERASE,
      EXPOSE,
      CONVERT,
      R_SEL,
      R_CAP,
      R_WAIT
   } frame_state_t;

   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                      input int w);
      logic [GRAY_MAX_W-1:0] s;
      logic [GRAY_MAX_W-1:0] g;
      s = b >> 1;
      g = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         if (i < w) begin
            g[i] = (i == w - 1) ? b[i] : (b[i] ^ s[i]);
         end
      end
      return g;
   endfunction

   // Each binary bit is the XOR of all gray bits at or above it.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                      input int w);
      logic [GRAY_MAX_W-1:0] b;
      logic acc;
      b   = '0;
      acc = 1'b0;
      for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
         if (i < w) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_ramp_counter.sv
// Binary ramp counter with a gray copy registered alongside it; one step per enabled cycle.
// terminal flags the all-ones count; clear forces both registers back to zero.
module gray_ramp_counter
   import pixel_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             terminal
);

   logic [WIDTH-1:0] bin_next;

   assign bin_next = bin + WIDTH'(1);
   assign terminal = &bin;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         bin  <= '0;
         gray <= '0;
      end else if (enable) begin
         // Wraps to zero after terminal, so the ramp reads 0 once CONVERT ends.
         bin  <= bin_next;
         gray <= WIDTH'(bin2gray(GRAY_MAX_W'(bin_next), WIDTH));
      end
   end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame controller: ERASE -> EXPOSE -> CONVERT (gray ramp) -> READ, streaming decoded pixels.
// Outputs registered from next-state; READ takes 3 cycles/pixel and stalls on out_ready without loss.
module pixel_frame_sequencer
   import pixel_pkg::*;
#(
   parameter int PIXEL_COUNT   = 4,
   parameter int COUNTER_WIDTH = 8,
   parameter int ERASE_CYCLES  = 4,
   parameter int EXPOSE_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           continuous,
   input  logic [EXPOSE_WIDTH-1:0]        expose_cycles,
   output logic                           erase,
   output logic                           expose,
   output logic                           convert,
   output logic                           read,
   output logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
   output logic [COUNTER_WIDTH-1:0]       ramp_gray,
   input  logic [COUNTER_WIDTH-1:0]       pixel_gray,
   output logic [COUNTER_WIDTH-1:0]       out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           busy,
   output logic                           frame_done
);

   localparam int SEL_W   = $clog2(PIXEL_COUNT);
   localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
   localparam int CNT_W   = (EXPOSE_WIDTH > ERASE_W) ? EXPOSE_WIDTH : ERASE_W;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(PIXEL_COUNT - 1);

   frame_state_t state, next_state;

   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         expose_load;
   logic [EXPOSE_WIDTH-1:0]  expose_lat;
   logic [SEL_W-1:0]         idx;
   logic                     cnt_zero;
   logic                     accept;
   logic                     last_pix;
   logic                     ramp_clear;
   logic                     ramp_terminal;
   logic [COUNTER_WIDTH-1:0] ramp_bin;

   assign cnt_zero     = (cnt == '0);
   assign accept       = (state == R_WAIT) && out_ready;
   assign last_pix     = (idx == LAST_IDX);
   assign expose_load  = (expose_lat == '0) ? '0 : CNT_W'(expose_lat - EXPOSE_WIDTH'(1));
   assign pixel_select = idx;
   assign ramp_clear   = (state != CONVERT) && (ramp_bin != '0);

   gray_ramp_counter #(
      .WIDTH(COUNTER_WIDTH)
   ) u_ramp (
      .clk     (clk),
      .reset   (reset),
      .enable  (state == CONVERT),
      .clear   (ramp_clear),
      .bin     (ramp_bin),
      .gray    (ramp_gray),
      .terminal(ramp_terminal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ERASE;
         ERASE:   if (cnt_zero) next_state = EXPOSE;
         EXPOSE:  if (cnt_zero) next_state = CONVERT;
         CONVERT: if (ramp_terminal) next_state = R_SEL;
         R_SEL:   next_state = R_CAP;
         R_CAP:   next_state = R_WAIT;
         R_WAIT: begin
            if (out_ready) begin
               if (last_pix) next_state = continuous ? ERASE : IDLE;
               else          next_state = R_SEL;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         expose_lat <= '0;
         idx        <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         erase      <= 1'b0;
         expose     <= 1'b0;
         convert    <= 1'b0;
         read       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // One down-counter serves both ERASE and EXPOSE; exposure is frozen at ERASE entry.
         if ((state != ERASE) && (next_state == ERASE)) begin
            expose_lat <= expose_cycles;
            cnt        <= CNT_W'(ERASE_CYCLES - 1);
         end else if ((state == ERASE) && (next_state == EXPOSE)) begin
            cnt <= expose_load;
         end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (accept) begin
            idx <= last_pix ? '0 : (idx + SEL_W'(1));
         end

         if (state == R_CAP) begin
            out_data  <= COUNTER_WIDTH'(gray2bin(GRAY_MAX_W'(pixel_gray), COUNTER_WIDTH));
            out_valid <= 1'b1;
            out_last  <= last_pix;
         end else if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         frame_done <= accept && last_pix;
         erase      <= (next_state == ERASE);
         expose     <= (next_state == EXPOSE);
         convert    <= (next_state == CONVERT);
         read       <= (next_state == R_SEL) || (next_state == R_CAP) || (next_state == R_WAIT);
         busy       <= (next_state != IDLE);
      end
   end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed frame sequence with randomized pixels/exposure, checked cycle by cycle
// against the frame timeline derived from the state durations.
module tb_pixel_frame_sequencer;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int EC = 4;
   localparam int EW = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 continuous;
   logic [EW-1:0]        expose_cycles;
   logic                 erase, expose, convert, read;
   logic [$clog2(N)-1:0] pixel_select;
   logic [W-1:0]         ramp_gray;
   logic [W-1:0]         pixel_gray;
   logic [W-1:0]         out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic                 busy;
   logic                 frame_done;

   logic [W-1:0] pix [N];
   int checks = 0;
   int errors = 0;
   int accepts = 0;

   always #5 clk = ~clk;

   // Sensor array model: selected pixel drives its gray code while read is high.
   assign pixel_gray = read ? (pix[pixel_select] ^ (pix[pixel_select] >> 1)) : '0;

   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) accepts++;
   end

   pixel_frame_sequencer #(
      .PIXEL_COUNT(N), .COUNTER_WIDTH(W), .ERASE_CYCLES(EC), .EXPOSE_WIDTH(EW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .expose_cycles(expose_cycles), .erase(erase), .expose(expose), .convert(convert),
      .read(read), .pixel_select(pixel_select), .ramp_gray(ramp_gray),
      .pixel_gray(pixel_gray), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_done(frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_strobes"}, 32'({erase, expose, convert, read}), 0);
      chk({tag, "_sel"}, 32'(pixel_select), 0);
      chk({tag, "_ramp"}, 32'(ramp_gray), 0);
      chk({tag, "_data"}, 32'(out_data), 0);
      chk({tag, "_flags"}, 32'({out_valid, out_last, busy, frame_done}), 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_strobes"}, 32'({erase, expose, convert, read}), 0);
      chk({tag, "_flags"}, 32'({out_valid, out_last, busy, frame_done}), 0);
      chk({tag, "_ramp"}, 32'(ramp_gray), 0);
   endtask

   task automatic randomize_pixels();
      for (int p = 0; p < N; p++) pix[p] = W'($urandom_range(0, (1 << W) - 1));
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Entered at the first ERASE cycle; returns at the frame_done cycle.
   task automatic run_frame(input int e, input bit cont, input int next_e,
                            input int bp_pix, input int bp_len);
      int n_exp;
      int w;
      bit done;
      logic [W-1:0] prev;
      n_exp = (e == 0) ? 1 : e;
      for (int i = 0; i < EC; i++) begin
         chk("erase", 32'(erase), 1);
         chk("erase_excl", 32'({expose, convert, read}), 0);
         chk("erase_busy", 32'(busy), 1);
         if (i > 0) chk("erase_fd_low", 32'(frame_done), 0);
         step();
      end
      for (int i = 0; i < n_exp; i++) begin
         chk("expose", 32'(expose), 1);
         chk("expose_excl", 32'({erase, convert, read, busy}), 1);
         if (i == 0) expose_cycles = EW'($urandom_range(0, 40));
         step();
      end
      prev = '0;
      for (int k = 0; k < (1 << W); k++) begin
         chk("convert", 32'(convert), 1);
         chk("convert_excl", 32'({erase, expose, read, busy}), 1);
         chk("ramp", 32'(ramp_gray), 32'(k ^ (k >> 1)));
         if (k > 0) chk("ramp_onebit", 32'($countones(ramp_gray ^ prev)), 1);
         prev  = ramp_gray;
         start = (k == 5);
         step();
      end
      start = 1'b0;
      chk("ramp_after", 32'(ramp_gray), 0);
      chk("convert_off", 32'(convert), 0);
      for (int p = 0; p < N; p++) begin
         chk("sel_read", 32'({erase, expose, convert, read}), 1);
         chk("sel_idx", 32'(pixel_select), 32'(p));
         chk("sel_valid", 32'(out_valid), 0);
         step();
         chk("cap_read", 32'(read), 1);
         chk("cap_idx", 32'(pixel_select), 32'(p));
         chk("cap_valid", 32'(out_valid), 0);
         step();
         w = 0;
         done = 1'b0;
         while (!done) begin
            chk("wait_valid", 32'(out_valid), 1);
            chk("wait_data", 32'(out_data), 32'(pix[p]));
            chk("wait_last", 32'(out_last), 32'(p == N - 1));
            chk("wait_read", 32'({read, busy, frame_done}), 6);
            chk("wait_idx", 32'(pixel_select), 32'(p));
            if (p == N - 1) begin
               continuous    = cont;
               expose_cycles = EW'(next_e);
            end
            out_ready = !((p == bp_pix) && (w < bp_len));
            done = out_ready;
            step();
            w++;
         end
      end
      chk("fd_pulse", 32'(frame_done), 1);
      chk("fd_read", 32'(read), 0);
      chk("fd_valid", 32'(out_valid), 0);
      chk("fd_busy", 32'(busy), 32'(cont));
      chk("fd_erase", 32'(erase), 32'(cont));
   endtask

   initial begin
      int e1, e2, e3, acc0;
      bit seen;
      reset = 1'b1;
      start = 1'b0;
      continuous = 1'b0;
      expose_cycles = EW'(3);
      out_ready = 1'b1;
      for (int p = 0; p < N; p++) pix[p] = '0;
      repeat (3) step();
      chk_zero("reset");
      reset = 1'b0;
      repeat (2) step();
      chk_idle("idle_no_start");

      // Single shot, fixed pixels
      pix[0] = 4'd5; pix[1] = 4'd9; pix[2] = 4'd0; pix[3] = 4'd15;
      expose_cycles = EW'(3);
      acc0 = accepts;
      do_start();
      run_frame(3, 1'b0, 0, -1, 0);
      step();
      chk_idle("single_end");
      chk("single_accepts", 32'(accepts - acc0), 4);
      repeat (2) step();
      chk_idle("single_stays_idle");

      // Zero exposure plus backpressure on pixel 2
      randomize_pixels();
      expose_cycles = '0;
      do_start();
      run_frame(0, 1'b0, 0, 2, 10);
      step();
      chk_idle("bp_end");

      // Random exposure
      randomize_pixels();
      e1 = $urandom_range(1, 9);
      expose_cycles = EW'(e1);
      do_start();
      run_frame(e1, 1'b0, 0, $urandom_range(0, N - 1), $urandom_range(1, 4));
      step();
      chk_idle("rand_end");

      // Three continuous frames
      e1 = $urandom_range(1, 6);
      e2 = $urandom_range(0, 6);
      e3 = $urandom_range(1, 6);
      acc0 = accepts;
      randomize_pixels();
      expose_cycles = EW'(e1);
      do_start();
      run_frame(e1, 1'b1, e2, 1, 3);
      randomize_pixels();
      run_frame(e2, 1'b1, e3, -1, 0);
      randomize_pixels();
      run_frame(e3, 1'b0, 0, 3, 2);
      continuous = 1'b0;
      step();
      chk_idle("cont_end");
      chk("cont_accepts", 32'(accepts - acc0), 12);

      // Reset while a pixel is held valid
      randomize_pixels();
      expose_cycles = EW'(2);
      do_start();
      out_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else step();
      end
      chk("rst_pre_valid", 32'({out_valid, read}), 3);
      reset = 1'b1;
      step();
      chk_zero("rst_mid");
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      chk_idle("rst_idle");
      randomize_pixels();
      expose_cycles = EW'(5);
      do_start();
      run_frame(5, 1'b0, 0, -1, 0);
      step();
      chk_idle("rst_frame_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
